// File: rtl/life_scheduler_pkg.sv
// Shared types and speed constants for the life_logic generation scheduler.
package life_scheduler_pkg;

  localparam int LOG_MAX_SPEED = 3;
  localparam int MAX_SPEED     = 2**LOG_MAX_SPEED;
  localparam int CNT_W         = LOG_MAX_SPEED + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, SWAP} sched_state_t;

  // Frames between evolve passes; the top speed setting gives one per frame.
  function automatic logic [CNT_W-1:0] period_of(input logic [LOG_MAX_SPEED-1:0] speed);
    return CNT_W'(MAX_SPEED) - CNT_W'(speed);
  endfunction

endpackage

// File: rtl/life_scheduler_frame_divider.sv
// Counts video frames while running and raises a level when an evolve pass is due.
module life_scheduler_frame_divider
  import life_scheduler_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_tick_in,
  input  logic                     run_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     clear_in,
  output logic                     due_out
);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, period;

  // Compared against the live speed setting, so a speed-up can make a pass due at once.
  always_comb begin
    period      = period_of(speed_in);
    frame_cnt_d = frame_cnt_q;
    if (clear_in)
      frame_cnt_d = '0;
    else if (frame_tick_in && run_in && (frame_cnt_q < period))
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign due_out = run_in && (frame_cnt_q >= period);

endmodule

// File: rtl/life_scheduler.sv
// life_scheduler: launches life_logic passes and flips the display bank on a frame tick.
// Optional pass watchdog is built in when SCHED_WATCHDOG_EN is defined.
// state     | meaning
// IDLE      | waiting for an evolve or edit request
// LAUNCH    | start pulse to life_logic
// WAIT_DONE | pass running; done on the first cycle is stale and ignored
// SWAP      | pass finished; bank flip on the next frame tick
module life_scheduler
  import life_scheduler_pkg::*;
#(
  parameter int GEN_W           = 16,
  parameter int WATCHDOG_CYCLES = 2**20
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_tick_in,
  input  logic                     run_in,
  input  logic                     step_in,
  input  logic                     click_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     logic_done_in,
  output logic                     logic_start_out,
  output logic                     update_out,
  output logic                     buf_sel_out,
  output logic [GEN_W-1:0]         gen_count_out,
  output logic                     busy_out,
  output logic                     error_out
);

  sched_state_t state_q;
  logic         step_pend_q, click_pend_q, first_wait_q;
  logic         due, evolve_due, launch, clear_cnt;

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
`else
  assign error_out = 1'b0;
`endif

  life_scheduler_frame_divider u_frame_divider (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .frame_tick_in (frame_tick_in),
    .run_in        (run_in),
    .speed_in      (speed_in),
    .clear_in      (clear_cnt),
    .due_out       (due)
  );

  // Evolve takes priority over a pending edit; the edit is applied inside the same pass.
  assign evolve_due = due || step_pend_q;
  assign launch     = (state_q == IDLE) && (evolve_due || click_pend_q);
  assign clear_cnt  = (state_q == IDLE) && evolve_due;
  assign busy_out   = (state_q != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      logic_start_out <= 1'b0;
      update_out      <= 1'b0;
      buf_sel_out     <= 1'b0;
      gen_count_out   <= '0;
      step_pend_q     <= 1'b0;
      click_pend_q    <= 1'b0;
      first_wait_q    <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wd_q            <= '0;
      error_out       <= 1'b0;
`endif
    end else begin
      step_pend_q  <= (step_pend_q && !launch) || (step_in && !run_in);
      click_pend_q <= (click_pend_q && !launch) || click_in;
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q         <= LAUNCH;
            logic_start_out <= 1'b1;
            update_out      <= evolve_due;
          end
        end
        LAUNCH: begin
          logic_start_out <= 1'b0;
          first_wait_q    <= 1'b1;
          state_q         <= WAIT_DONE;
`ifdef SCHED_WATCHDOG_EN
          wd_q            <= WD_W'(WATCHDOG_CYCLES - 1);
`endif
        end
        WAIT_DONE: begin
          first_wait_q <= 1'b0;
          if (!first_wait_q && logic_done_in)
            state_q <= SWAP;
`ifdef SCHED_WATCHDOG_EN
          else if (wd_q == '0) begin
            error_out <= 1'b1;
            state_q   <= IDLE;
          end else
            wd_q <= wd_q - WD_W'(1);
`endif
        end
        SWAP: begin
          if (frame_tick_in) begin
            buf_sel_out   <= ~buf_sel_out;
            gen_count_out <= gen_count_out + GEN_W'(update_out);
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
